// File: rtl/motoro3_step_sequencer.sv
// rtl/motoro3_step_sequencer.sv - commutation step sequencer with open-loop soft-start ramp
module motoro3_step_sequencer #(
    parameter int STEP_LAST = 11,
    parameter int PER_MIN   = 3
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        m3r_run,
    input  logic [24:0] m3r_stepLenStart,
    input  logic [24:0] m3r_stepLenMin,
    input  logic [15:0] m3r_accelDec,
    input  logic [15:0] m3r_plLenStart,
    input  logic [15:0] m3r_plLenRun,
    output logic [3:0]  sgStep,
    output logic [15:0] plLen,
    output logic [24:0] m3cnt,
    output logic        m3cntLast2,
    output logic        m3cntLast1,
    output logic        running,
    output logic        ramping
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [24:0] PER_FLOOR = 25'(PER_MIN);
    localparam logic [3:0]  STEP_MAX  = 4'(STEP_LAST);

    state_t      state, state_nxt;
    logic [24:0] cur_per, cur_per_nxt;
    logic [3:0]  step_nxt;
    logic [15:0] pl_len_nxt;
    logic [24:0] cnt_nxt;

    logic [24:0] eff_start;
    logic [24:0] eff_min;
    logic [25:0] ramp_diff;
    logic        ramp_done;

    // Periods below the floor are clamped; the ramp ends on borrow or on reaching the target.
    always_comb begin
        eff_start = (m3r_stepLenStart < PER_FLOOR) ? PER_FLOOR : m3r_stepLenStart;
        eff_min   = (m3r_stepLenMin < PER_FLOOR) ? PER_FLOOR : m3r_stepLenMin;
        ramp_diff = {1'b0, cur_per} - {10'd0, m3r_accelDec};
        ramp_done = ramp_diff[25] || (ramp_diff[24:0] <= eff_min);
    end

    // State and datapath registers, all on the falling edge.
    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            cur_per <= '0;
            sgStep  <= '0;
            plLen   <= '0;
            m3cnt   <= '0;
        end else begin
            state   <= state_nxt;
            cur_per <= cur_per_nxt;
            sgStep  <= step_nxt;
            plLen   <= pl_len_nxt;
            m3cnt   <= cnt_nxt;
        end
    end

    // Next-state: start from IDLE, count down, and apply step-boundary actions at m3cnt==0.
    always_comb begin
        state_nxt   = state;
        cur_per_nxt = cur_per;
        step_nxt    = sgStep;
        pl_len_nxt  = plLen;
        cnt_nxt     = m3cnt;
        case (state)
            IDLE: begin
                if (m3r_run) begin
                    step_nxt = '0;
                    if (eff_start > eff_min) begin
                        state_nxt   = RAMP;
                        cur_per_nxt = eff_start;
                        pl_len_nxt  = m3r_plLenStart;
                    end else begin
                        state_nxt   = RUN;
                        cur_per_nxt = eff_min;
                        pl_len_nxt  = m3r_plLenRun;
                    end
                    cnt_nxt = cur_per_nxt - 25'd1;
                end
            end
            RAMP, RUN: begin
                if (m3cnt != '0) begin
                    cnt_nxt = m3cnt - 25'd1;
                end else if (!m3r_run) begin
                    state_nxt   = IDLE;
                    cur_per_nxt = '0;
                    step_nxt    = '0;
                    pl_len_nxt  = '0;
                    cnt_nxt     = '0;
                end else begin
                    step_nxt = (sgStep == STEP_MAX) ? 4'd0 : sgStep + 4'd1;
                    if (state == RAMP && !ramp_done) begin
                        cur_per_nxt = ramp_diff[24:0];
                        pl_len_nxt  = m3r_plLenStart;
                    end else begin
                        state_nxt   = RUN;
                        cur_per_nxt = eff_min;
                        pl_len_nxt  = m3r_plLenRun;
                    end
                    cnt_nxt = cur_per_nxt - 25'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                cur_per_nxt = '0;
                step_nxt    = '0;
                pl_len_nxt  = '0;
                cnt_nxt     = '0;
            end
        endcase
    end

    // Strobes and status decoded from registered state and counter only.
    always_comb begin
        running    = (state != IDLE);
        ramping    = (state == RAMP);
        m3cntLast2 = running && (m3cnt == 25'd1);
        m3cntLast1 = running && (m3cnt == 25'd0);
    end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// tb/tb_motoro3_step_sequencer.sv - scoreboard bench for motoro3_step_sequencer
module tb_motoro3_step_sequencer;

    logic        clk;
    logic        nRst;
    logic        m3r_run;
    logic [24:0] m3r_stepLenStart;
    logic [24:0] m3r_stepLenMin;
    logic [15:0] m3r_accelDec;
    logic [15:0] m3r_plLenStart;
    logic [15:0] m3r_plLenRun;
    logic [3:0]  sgStep;
    logic [15:0] plLen;
    logic [24:0] m3cnt;
    logic        m3cntLast2;
    logic        m3cntLast1;
    logic        running;
    logic        ramping;

    typedef struct {
        int   per;
        int   step;
        int   pl;
        logic ramp;
    } step_rec_t;

    step_rec_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    motoro3_step_sequencer #(.STEP_LAST(11), .PER_MIN(3)) dut (
        .clk(clk),
        .nRst(nRst),
        .m3r_run(m3r_run),
        .m3r_stepLenStart(m3r_stepLenStart),
        .m3r_stepLenMin(m3r_stepLenMin),
        .m3r_accelDec(m3r_accelDec),
        .m3r_plLenStart(m3r_plLenStart),
        .m3r_plLenRun(m3r_plLenRun),
        .sgStep(sgStep),
        .plLen(plLen),
        .m3cnt(m3cnt),
        .m3cntLast2(m3cntLast2),
        .m3cntLast1(m3cntLast1),
        .running(running),
        .ramping(ramping)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int per, input int step, input int pl, input logic ramp);
        step_rec_t r;
        r.per  = per;
        r.step = step;
        r.pl   = pl;
        r.ramp = ramp;
        sb.push_back(r);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (sb.size() == 0) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL drain_timeout: %0d steps still expected", sb.size());
        sb.delete();
    endtask

    task automatic stop_dut();
        @(posedge clk);
        #1 m3r_run = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (!running) return;
        end
        check("stop_timeout", 32'(running), 32'd0);
    endtask

    task automatic configure(input int st, input int mn, input int dec, input int pls, input int plr);
        m3r_stepLenStart = 25'(st);
        m3r_stepLenMin   = 25'(mn);
        m3r_accelDec     = 16'(dec);
        m3r_plLenStart   = 16'(pls);
        m3r_plLenRun     = 16'(plr);
    endtask

    // Monitor: measures each completed step and compares it with the next expected record.
    initial begin
        int        len;
        int        l2cnt;
        step_rec_t e;
        len   = 0;
        l2cnt = 0;
        forever begin
            @(posedge clk);
            if (!nRst || !running) begin
                len   = 0;
                l2cnt = 0;
            end else begin
                len++;
                if (m3cntLast2) l2cnt++;
                if (m3cntLast1) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("step_period", 32'(len), 32'(e.per));
                        check("step_index", 32'(sgStep), 32'(e.step));
                        check("step_pllen", 32'(plLen), 32'(e.pl));
                        check("step_ramping", 32'(ramping), 32'(e.ramp));
                        check("step_last2_count", 32'(l2cnt), 32'd1);
                    end
                    len   = 0;
                    l2cnt = 0;
                end
            end
        end
    end

    initial begin
        bit found;
        nRst    = 1'b0;
        m3r_run = 1'b0;
        configure(20, 8, 4, 'h100, 'h200);
        repeat (3) @(posedge clk);
        check("reset_running", 32'(running), 32'd0);
        check("reset_m3cnt", 32'(m3cnt), 32'd0);
        check("reset_pllen", 32'(plLen), 32'd0);
        #1 nRst = 1'b1;

        // Ramp 20,16,12 then run at 8, step index wrapping after 11.
        for (int i = 0; i < 14; i++)
            push((i < 3) ? 20 - 4 * i : 8, i % 12, (i < 3) ? 'h100 : 'h200, (i < 3) ? 1'b1 : 1'b0);
        @(posedge clk);
        #1 m3r_run = 1'b1;
        drain(400);
        stop_dut();

        // Borrow on a huge decrement ends the ramp at the target period.
        configure(10, 6, 'h0FFF, 'h111, 'h222);
        push(10, 0, 'h111, 1'b1);
        push(6, 1, 'h222, 1'b0);
        push(6, 2, 'h222, 1'b0);
        #1 m3r_run = 1'b1;
        drain(100);
        stop_dut();

        // Floor: both periods below PER_MIN, straight to RUN at 3 clocks.
        configure(1, 2, 4, 'h0AA, 'h0BB);
        push(3, 0, 'h0BB, 1'b0);
        push(3, 1, 'h0BB, 1'b0);
        #1 m3r_run = 1'b1;
        @(posedge clk);
        check("floor_cnt2", 32'(m3cnt), 32'd2);
        check("floor_last2_lo", 32'(m3cntLast2), 32'd0);
        @(posedge clk);
        check("floor_cnt1", 32'(m3cnt), 32'd1);
        check("floor_last2_hi", 32'(m3cntLast2), 32'd1);
        check("floor_last1_lo", 32'(m3cntLast1), 32'd0);
        @(posedge clk);
        check("floor_cnt0", 32'(m3cnt), 32'd0);
        check("floor_last1_hi", 32'(m3cntLast1), 32'd1);
        check("floor_ramping", 32'(ramping), 32'd0);
        drain(50);
        stop_dut();

        // Live update in RUN takes effect only at the next boundary.
        configure(8, 8, 4, 'h100, 'h200);
        push(8, 0, 'h200, 1'b0);
        push(12, 1, 'h300, 1'b0);
        push(12, 2, 'h300, 1'b0);
        #1 m3r_run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            found = running && (sgStep == 4'd0) && (m3cnt == 25'd4);
        end
        check("live_found", 32'(found), 32'd1);
        #1 configure(8, 12, 4, 'h100, 'h300);
        drain(100);
        stop_dut();

        // Stop at m3cnt=5 of step 3, rerun asserted right after the boundary edge.
        configure(8, 8, 4, 'h100, 'h200);
        for (int i = 0; i < 4; i++) push(8, i, 'h200, 1'b0);
        #1 m3r_run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            found = running && (sgStep == 4'd3) && (m3cnt == 25'd5);
        end
        check("stop_found", 32'(found), 32'd1);
        #1 m3r_run = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            found = m3cntLast1 && (sgStep == 4'd3);
        end
        check("stop_last1_seen", 32'(found), 32'd1);
        @(negedge clk);
        #1 m3r_run = 1'b1;
        @(posedge clk);
        check("stop_idle_running", 32'(running), 32'd0);
        check("stop_idle_step", 32'(sgStep), 32'd0);
        check("stop_idle_pllen", 32'(plLen), 32'd0);
        check("stop_idle_cnt", 32'(m3cnt), 32'd0);
        @(posedge clk);
        check("restart_running", 32'(running), 32'd1);
        check("restart_cnt", 32'(m3cnt), 32'd7);
        check("restart_pllen", 32'(plLen), 32'h200);
        check("stop_sb_empty", 32'(sb.size()), 32'd0);
        stop_dut();

        // Asynchronous reset mid-ramp, then the ramp restarts from the start period.
        configure(20, 8, 4, 'h100, 'h200);
        #1 m3r_run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            found = ramping && (sgStep == 4'd0) && (m3cnt == 25'd7);
        end
        check("rst_found", 32'(found), 32'd1);
        #2 nRst = 1'b0;
        #1;
        check("rst_async_running", 32'(running), 32'd0);
        check("rst_async_ramping", 32'(ramping), 32'd0);
        check("rst_async_cnt", 32'(m3cnt), 32'd0);
        check("rst_async_pllen", 32'(plLen), 32'd0);
        check("rst_async_step", 32'(sgStep), 32'd0);
        check("rst_async_strobes", 32'({m3cntLast2, m3cntLast1}), 32'd0);
        push(20, 0, 'h100, 1'b1);
        push(16, 1, 'h100, 1'b1);
        @(posedge clk);
        #1 nRst = 1'b1;
        drain(100);
        stop_dut();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
